// File: rtl/decode_q_pkg.sv
// rtl/decode_q_pkg.sv - shared opcode, control-field encodings and decoded control word for decode_q
package decode_q_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] FCT3_BEQ  = 3'b000;
  localparam logic [2:0] FCT3_BNE  = 3'b001;
  localparam logic [2:0] FCT3_BLT  = 3'b100;
  localparam logic [2:0] FCT3_BGE  = 3'b101;
  localparam logic [2:0] FCT3_BLTU = 3'b110;
  localparam logic [2:0] FCT3_BGEU = 3'b111;

  localparam logic [2:0] MEMB_NONE = 3'b000;
  localparam logic [2:0] MEMB_EQ   = 3'b001;
  localparam logic [2:0] MEMB_NE   = 3'b010;
  localparam logic [2:0] MEMB_JAL  = 3'b011;
  localparam logic [2:0] MEMB_JALR = 3'b100;
  localparam logic [2:0] MEMB_LT   = 3'b101;
  localparam logic [2:0] MEMB_GE   = 3'b110;

  localparam logic [2:0] ALU_co_RTYPE  = 3'b000;
  localparam logic [2:0] ALU_co_ITYPE  = 3'b001;
  localparam logic [2:0] ALU_co_MEM    = 3'b010;
  localparam logic [2:0] ALU_co_BRANCH = 3'b011;
  localparam logic [2:0] ALU_co_SYS    = 3'b100;
  localparam logic [2:0] ALU_co_EBREAK = 3'b101;
  localparam logic [2:0] ALU_co_MRET   = 3'b110;
  localparam logic [2:0] ALU_co_UPPER  = 3'b111;

  localparam logic [1:0] write_reg_ALU = 2'b00;
  localparam logic [1:0] write_reg_MEM = 2'b01;
  localparam logic [1:0] write_reg_PC4 = 2'b10;

  localparam logic [1:0] MEMRW_NONE  = 2'b00;
  localparam logic [1:0] MEMRW_STORE = 2'b01;
  localparam logic [1:0] MEMRW_LOAD  = 2'b10;

  // bit0: B operand is imm, bit1: A operand is pc, bit2: A operand is zero
  localparam logic [2:0] ALU_SRC_RS       = 3'b000;
  localparam logic [2:0] ALU_SRC_IMM      = 3'b001;
  localparam logic [2:0] ALU_SRC_PC_IMM   = 3'b011;
  localparam logic [2:0] ALU_SRC_ZERO_IMM = 3'b101;

  typedef enum logic [2:0] {IMM_Z, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_t;

  typedef struct packed {
    logic [31:0] imm;
    logic [3:0]  alu_c;
    logic [4:0]  wreg;
    logic        regwrite;
    logic [1:0]  memtoreg;
    logic [1:0]  memrw;
    logic [2:0]  membranch;
    logic [2:0]  alu_control;
    logic [2:0]  alu_src;
    logic        illegal;
  } ctrl_t;

  function automatic logic [31:0] imm_of(input imm_fmt_t fmt, input logic [31:0] inst);
    case (fmt)
      IMM_I:   return {{20{inst[31]}}, inst[31:20]};
      IMM_S:   return {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   return {inst[31:12], 12'b0};
      IMM_J:   return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/decode_q_fifo.sv
// rtl/decode_q_fifo.sv - DEPTH-entry synchronous FIFO with occupancy count and flush
module decode_q_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [W-1:0]     wdata,
  input  logic             pop,
  output logic [W-1:0]     rdata,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en && !rd_en)      count <= count + (PTR_W+1)'(1);
      else if (!wr_en && rd_en) count <= count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/decode_q.sv
// rtl/decode_q.sv - RV32I decode stage with input queue and stallable output register
// Optional: define DECODE_SYSTEM_EN to decode fence and system opcodes instead of flagging them illegal.
module decode_q
  import decode_q_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic [4:0]      read_reg1,
  output logic [4:0]      read_reg2,
  input  logic [XLEN-1:0] read_data1,
  input  logic [XLEN-1:0] read_data2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pcp4,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [3:0]      out_alu_c,
  output logic [4:0]      out_wreg,
  output logic            out_regwrite,
  output logic [1:0]      out_memtoreg,
  output logic [1:0]      out_memrw,
  output logic [2:0]      out_membranch,
  output logic [2:0]      out_alu_control,
  output logic [2:0]      out_alu_src,
  output logic [6:0]      out_funct7,
  output logic [31:0]     out_inst,
  output logic            out_illegal
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcp4;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [31:0]     inst;
    ctrl_t           ctrl;
  } stage_t;

  function automatic ctrl_t decode(input logic [31:0] inst);
    ctrl_t    c;
    imm_fmt_t fmt;
    logic     wr;
    c       = '0;
    fmt     = IMM_Z;
    wr      = 1'b0;
    c.alu_c = {1'b0, inst[14:12]};
    case (inst[6:0])
      OPC_LUI:   begin fmt = IMM_U; wr = 1'b1; c.alu_control = ALU_co_UPPER; c.alu_src = ALU_SRC_ZERO_IMM; end
      OPC_AUIPC: begin fmt = IMM_U; wr = 1'b1; c.alu_control = ALU_co_UPPER; c.alu_src = ALU_SRC_PC_IMM; end
      OPC_JAL: begin
        fmt = IMM_J; wr = 1'b1; c.memtoreg = write_reg_PC4; c.membranch = MEMB_JAL;
        c.alu_c = 4'b0000; c.alu_control = ALU_co_BRANCH; c.alu_src = ALU_SRC_PC_IMM;
      end
      OPC_JALR: begin
        fmt = IMM_I; wr = 1'b1; c.memtoreg = write_reg_PC4; c.membranch = MEMB_JALR;
        c.alu_c = 4'b0001; c.alu_control = ALU_co_BRANCH; c.alu_src = ALU_SRC_IMM;
      end
      OPC_BRANCH: begin
        fmt = IMM_B; c.alu_control = ALU_co_BRANCH; c.alu_src = ALU_SRC_RS;
        // unsigned compares share lt/ge; funct3 in alu_c tells EX the signedness
        case (inst[14:12])
          FCT3_BEQ:             c.membranch = MEMB_EQ;
          FCT3_BNE:             c.membranch = MEMB_NE;
          FCT3_BLT, FCT3_BLTU:  c.membranch = MEMB_LT;
          FCT3_BGE, FCT3_BGEU:  c.membranch = MEMB_GE;
          default:              c.membranch = MEMB_NONE;
        endcase
      end
      OPC_LOAD: begin
        fmt = IMM_I; wr = 1'b1; c.memtoreg = write_reg_MEM; c.memrw = MEMRW_LOAD;
        c.alu_control = ALU_co_MEM; c.alu_src = ALU_SRC_IMM;
      end
      OPC_STORE: begin fmt = IMM_S; c.memrw = MEMRW_STORE; c.alu_control = ALU_co_MEM; c.alu_src = ALU_SRC_IMM; end
      OPC_OPIMM: begin fmt = IMM_I; wr = 1'b1; c.alu_control = ALU_co_ITYPE; c.alu_src = ALU_SRC_IMM; end
      OPC_OP: begin
        wr = 1'b1; c.alu_c = {inst[30], inst[14:12]};
        c.alu_control = ALU_co_RTYPE; c.alu_src = ALU_SRC_RS;
      end
`ifdef DECODE_SYSTEM_EN
      OPC_FENCE: c.alu_control = ALU_co_SYS;
      OPC_SYSTEM: begin
        if (inst[14:12] == 3'b000) begin
          case (inst[31:20])
            12'h001: c.alu_control = ALU_co_EBREAK;
            12'h302: c.alu_control = ALU_co_MRET;
            default: c.alu_control = ALU_co_SYS;
          endcase
        end else begin
          fmt = IMM_I; wr = 1'b1; c.memtoreg = write_reg_ALU;
          c.alu_control = ALU_co_SYS; c.alu_src = ALU_SRC_IMM;
        end
      end
`endif
      default: begin
        c.alu_c   = 4'b0000;
        c.illegal = 1'b1;
      end
    endcase
    c.imm      = imm_of(fmt, inst);
    c.wreg     = wr ? inst[11:7] : 5'd0;
    c.regwrite = wr && (inst[11:7] != 5'd0);
    return c;
  endfunction

  logic [XLEN+31:0] head;
  logic [XLEN-1:0]  head_pc;
  logic [31:0]      head_inst;
  logic [PTR_W:0]   count;
  logic             full, empty, push, pop, load_en;
  ctrl_t            dec;
  stage_t           stage_q;

  assign in_ready  = !rst && !flush && !full;
  assign push      = in_valid && in_ready;
  assign load_en   = !stage_q.valid || out_ready;
  assign pop       = (count != '0) && load_en;
  assign head_pc   = head[XLEN+31:32];
  assign head_inst = head[31:0];
  assign read_reg1 = empty ? 5'd0 : head_inst[19:15];
  assign read_reg2 = empty ? 5'd0 : head_inst[24:20];
  assign dec       = decode(head_inst);

  decode_q_fifo #(.W(XLEN+32), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdata ({in_pc, in_inst}),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else if (flush) begin
      stage_q <= '0;
    end else if (load_en) begin
      if (count != '0) begin
        stage_q.valid <= 1'b1;
        stage_q.pc    <= head_pc;
        stage_q.pcp4  <= head_pc + XLEN'(4);
        stage_q.rs1   <= read_data1;
        stage_q.rs2   <= read_data2;
        stage_q.inst  <= head_inst;
        stage_q.ctrl  <= dec;
      end else begin
        stage_q.valid <= 1'b0;
      end
    end
  end

  assign out_valid       = stage_q.valid;
  assign out_pc          = stage_q.pc;
  assign out_pcp4        = stage_q.pcp4;
  assign out_rs1_data    = stage_q.rs1;
  assign out_rs2_data    = stage_q.rs2;
  assign out_imm         = XLEN'($signed(stage_q.ctrl.imm));
  assign out_alu_c       = stage_q.ctrl.alu_c;
  assign out_wreg        = stage_q.ctrl.wreg;
  assign out_regwrite    = stage_q.ctrl.regwrite;
  assign out_memtoreg    = stage_q.ctrl.memtoreg;
  assign out_memrw       = stage_q.ctrl.memrw;
  assign out_membranch   = stage_q.ctrl.membranch;
  assign out_alu_control = stage_q.ctrl.alu_control;
  assign out_alu_src     = stage_q.ctrl.alu_src;
  assign out_funct7      = stage_q.inst[31:25];
  assign out_inst        = stage_q.inst;
  assign out_illegal     = stage_q.ctrl.illegal;

endmodule
